// File: rtl/queue_pkg.sv
// Shared definitions for the bank-queue sensor front end: occupancy sizing,
// FSM state encoding and count-direction constants.
package queue_pkg;

  localparam int OCC_W        = 4;
  localparam int CAPACITY_DEF = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/sensor_debounce.sv
// One door sensor: 2-FF synchronizer, stability counter, and a one-cycle pulse
// on each accepted rising level.
module sensor_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // The level flips only after DEBOUNCE consecutive disagreeing samples.
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/queue_sensor_ctrl.sv
// Door-sensor front end for the queue counter: debounce, pending events, full/empty
// gating. Define QUEUE_SENSOR_STATS_EN to enable the saturating drop_count statistic.
module queue_sensor_ctrl
  import queue_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CAPACITY = CAPACITY_DEF,
  parameter int PEND_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sens_in,
  input  logic             sens_out,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             evt_up,
  output logic [OCC_W-1:0] occupancy,
  output logic             reject,
  output logic [7:0]       drop_count
);

  localparam int PW = $clog2(PEND_MAX + 1);

  state_t          state, state_nx;
  logic            rise_in, rise_out;
  logic [PW-1:0]   pend_in, pend_out;
  logic            dir_q, prio_up;
  logic            sel_up, contend, take, gate_drop, retire;
  logic            inc_in, inc_out, ovf_in, ovf_out, dec_in, dec_out;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_in (
    .clk(clk), .reset(reset), .raw(sens_in), .rise(rise_in)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_out (
    .clk(clk), .reset(reset), .raw(sens_out), .rise(rise_out)
  );

  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p,
                                              input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return p + 1'b1;
      2'b01:   return p - 1'b1;
      default: return p;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx  = state;
    sel_up    = DIR_DOWN;
    contend   = 1'b0;
    take      = 1'b0;
    gate_drop = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_in != '0 || pend_out != '0) begin
          take    = 1'b1;
          contend = (pend_in != '0) && (pend_out != '0);
          sel_up  = contend ? prio_up : (pend_in != '0);
          if ((sel_up && occupancy == OCC_W'(CAPACITY)) ||
              (!sel_up && occupancy == '0))
            gate_drop = 1'b1;
          else
            state_nx = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          retire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ovf_in  = rise_in  && (pend_in  == PW'(PEND_MAX));
  assign ovf_out = rise_out && (pend_out == PW'(PEND_MAX));
  assign inc_in  = rise_in  && !ovf_in;
  assign inc_out = rise_out && !ovf_out;
  assign dec_in  = (gate_drop && sel_up)  || (retire && dir_q == DIR_UP);
  assign dec_out = (gate_drop && !sel_up) || (retire && dir_q == DIR_DOWN);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_in   <= '0;
      pend_out  <= '0;
      dir_q     <= DIR_DOWN;
      prio_up   <= DIR_UP;
      occupancy <= '0;
      reject    <= 1'b0;
    end else begin
      pend_in  <= pend_next(pend_in, inc_in, dec_in);
      pend_out <= pend_next(pend_out, inc_out, dec_out);
      reject   <= ovf_in || ovf_out || gate_drop;
      if (take && !gate_drop) dir_q <= sel_up;
      // Priority flips only when both directions actually competed.
      if (contend) prio_up <= !sel_up;
      if (retire) occupancy <= (dir_q == DIR_UP) ? occupancy + 1'b1 : occupancy - 1'b1;
    end
  end

  assign evt_valid = (state == OFFER);
  assign evt_up    = dir_q;

`ifdef QUEUE_SENSOR_STATS_EN
  logic [7:0] drops;
  logic [7:0] drop_q;

  assign drops = 8'(ovf_in) + 8'(ovf_out) + 8'(gate_drop);

  always_ff @(posedge clk) begin
    if (reset)
      drop_q <= '0;
    else if (drops != '0)
      drop_q <= (drop_q > 8'd255 - drops) ? 8'd255 : drop_q + drops;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_queue_sensor_ctrl.sv
// Directed self-checking bench for queue_sensor_ctrl with hand-computed expectations.
module tb_queue_sensor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sens_in = 1'b0;
  logic       sens_out = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic       evt_up;
  logic [3:0] occupancy;
  logic       reject;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;
  int rej_seen = 0;
  int vld_seen = 0;
  int up_seen = 0;
  int dn_seen = 0;

  queue_sensor_ctrl dut (
    .clk(clk), .reset(reset), .sens_in(sens_in), .sens_out(sens_out),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_up(evt_up),
    .occupancy(occupancy), .reject(reject), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reject) rej_seen++;
    if (evt_valid) vld_seen++;
    if (evt_valid && evt_ready) begin
      if (evt_up) up_seen++;
      else        dn_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One person through a door: beam held hi cycles, then clear for lo cycles.
  task automatic pulse(input bit entry, input int hi, input int lo);
    if (entry) sens_in = 1'b1; else sens_out = 1'b1;
    tick(hi);
    sens_in  = 1'b0;
    sens_out = 1'b0;
    tick(lo);
  endtask

  int r0, v0, u0, d0;
  int exp_drop;
  int stable_bad;

  initial begin
    exp_drop = 0;

    // Reset state
    tick(3);
    check("reset_valid", 32'(evt_valid), 0);
    check("reset_occ", 32'(occupancy), 0);
    reset = 1'b0;
    tick();
    check("post_reset_up", 32'(evt_up), 0);
    check("post_reset_reject", 32'(reject), 0);
    check("post_reset_drop", 32'(drop_count), 0);

    // Clean entry: evt_valid appears in the 8th cycle after the rise
    sens_in = 1'b1;
    tick(7);
    check("lat_not_yet", 32'(evt_valid), 0);
    tick();
    check("lat_valid", 32'(evt_valid), 1);
    check("lat_up", 32'(evt_up), 1);
    tick();
    check("lat_retired", 32'(evt_valid), 0);
    check("lat_occ", 32'(occupancy), 1);
    tick(11);
    sens_in = 1'b0;
    tick(10);

    // Short glitch on the exit sensor is ignored
    r0 = rej_seen; v0 = vld_seen;
    pulse(1'b0, 3, 15);
    check("glitch_events", 32'(vld_seen - v0), 0);
    check("glitch_reject", 32'(rej_seen - r0), 0);
    check("glitch_occ", 32'(occupancy), 1);

    // Simultaneous rises at occupancy 5: up first, down two cycles later
    repeat (4) pulse(1'b1, 8, 10);
    check("occ_five", 32'(occupancy), 5);
    sens_in  = 1'b1;
    sens_out = 1'b1;
    tick(8);
    check("both_first_valid", 32'(evt_valid), 1);
    check("both_first_up", 32'(evt_up), 1);
    tick();
    check("both_gap", 32'(evt_valid), 0);
    check("both_mid_occ", 32'(occupancy), 6);
    tick();
    check("both_second_valid", 32'(evt_valid), 1);
    check("both_second_up", 32'(evt_up), 0);
    tick();
    check("both_end_occ", 32'(occupancy), 5);
    tick(8);
    sens_in  = 1'b0;
    sens_out = 1'b0;
    tick(10);

    // Drain to empty, then an exit from an empty queue is rejected
    repeat (5) pulse(1'b0, 8, 10);
    check("drained_occ", 32'(occupancy), 0);
    r0 = rej_seen; v0 = vld_seen;
    pulse(1'b0, 8, 10);
    check("empty_no_valid", 32'(vld_seen - v0), 0);
    check("empty_reject_cycles", 32'(rej_seen - r0), 1);
    check("empty_occ", 32'(occupancy), 0);
`ifdef QUEUE_SENSOR_STATS_EN
    exp_drop = 1;
`endif
    check("empty_drop_count", 32'(drop_count), 32'(exp_drop));

    // 16 entries from empty: 15 accepted, one rejected at capacity
    r0 = rej_seen; u0 = up_seen; d0 = dn_seen;
    repeat (16) pulse(1'b1, 8, 10);
    check("fill_up_events", 32'(up_seen - u0), 15);
    check("fill_down_events", 32'(dn_seen - d0), 0);
    check("fill_occ", 32'(occupancy), 15);
    check("fill_reject_cycles", 32'(rej_seen - r0), 1);
`ifdef QUEUE_SENSOR_STATS_EN
    exp_drop = 2;
`endif
    check("fill_drop_count", 32'(drop_count), 32'(exp_drop));

    // Back-pressure: the offered exit holds steady, then reset clears it
    evt_ready = 1'b0;
    sens_out  = 1'b1;
    for (int i = 0; i < 12 && !evt_valid; i++) tick();
    check("bp_offered", 32'(evt_valid), 1);
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!evt_valid || evt_up) stable_bad++;
    end
    check("bp_stable", 32'(stable_bad), 0);
    check("bp_occ_held", 32'(occupancy), 15);
    sens_out = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_mid_valid", 32'(evt_valid), 0);
    check("rst_mid_occ", 32'(occupancy), 0);
    check("rst_mid_drop", 32'(drop_count), 0);
    reset = 1'b0;
    evt_ready = 1'b1;
    tick(12);
    check("rst_nothing_pending", 32'(evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
